// File: rtl/wave_capture.sv
// wave_capture: writer side of the double-buffered 512x8 wave RAM.
// Arms on a rising zero crossing, stores 256 display-scaled samples into the
// half not being displayed, then swaps halves once the display is idle.
// Optional feature macro: TRIGGER_TIMEOUT_EN (forced trigger after
// TIMEOUT_SAMPLES non-trigger samples in ARMED, so a DC input still refreshes).
module wave_capture #(
  parameter int SAMPLE_W        = 16,
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  typedef enum logic [1:0] {S_ARMED, S_ACTIVE, S_WAIT} state_t;

  localparam logic [31:0] TIMEOUT_V = TIMEOUT_SAMPLES;

  state_t              state, state_n;
  logic [7:0]          count, count_n;
  logic [SAMPLE_W-1:0] prev_sample;
  logic                read_index_n;
  logic                we_n;
  logic [8:0]          addr_n;
  logic [7:0]          ws_n;
  logic                crossing;
  logic                timeout_hit;
  logic [7:0]          scaled;

  // Only the sign of the previous sample and the top byte of the new one
  // matter; the remaining bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{new_sample_in[SAMPLE_W-9:0], prev_sample[SAMPLE_W-2:0], TIMEOUT_V[0]};

  // Screen y grows downward, so invert the signed top byte around 127.
  assign scaled   = 8'd127 - new_sample_in[SAMPLE_W-1 -: 8];
  assign crossing = new_sample_ready && prev_sample[SAMPLE_W-1] && !new_sample_in[SAMPLE_W-1];

`ifdef TRIGGER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SAMPLES) + 1;
  logic [TW-1:0] tcount, tcount_n;
  // The sample that would bring the counter to TIMEOUT_SAMPLES is the trigger.
  assign timeout_hit = new_sample_ready && (tcount == TW'(TIMEOUT_SAMPLES - 1));

  // Non-trigger sample counter, only meaningful while ARMED.
  always_ff @(posedge clk) begin
    if (reset) tcount <= '0;
    else       tcount <= tcount_n;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Sample history is tracked in every state so a crossing can be seen
  // on the very first sample after re-arming.
  always_ff @(posedge clk) begin
    if (reset)                 prev_sample <= '0;
    else if (new_sample_ready) prev_sample <= new_sample_in;
  end

  // State, counter, buffer select and registered RAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_ARMED;
      count         <= '0;
      read_index    <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      read_index    <= read_index_n;
      write_enable  <= we_n;
      write_address <= addr_n;
      write_sample  <= ws_n;
    end
  end

  // Next-state and write-port decode.
  always_comb begin
    state_n      = state;
    count_n      = count;
    read_index_n = read_index;
    we_n         = 1'b0;
    addr_n       = write_address;
    ws_n         = write_sample;
`ifdef TRIGGER_TIMEOUT_EN
    tcount_n     = tcount;
`endif
    case (state)
      S_ARMED: begin
        if (crossing || timeout_hit) begin
          // A coincident timeout and real crossing is one trigger.
          we_n    = 1'b1;
          addr_n  = {~read_index, 8'd0};
          ws_n    = scaled;
          count_n = 8'd1;
          state_n = S_ACTIVE;
`ifdef TRIGGER_TIMEOUT_EN
        end else if (new_sample_ready) begin
          tcount_n = tcount + 1'b1;
`endif
        end
      end
      S_ACTIVE: begin
        if (new_sample_ready) begin
          we_n    = 1'b1;
          addr_n  = {~read_index, count};
          ws_n    = scaled;
          count_n = count + 8'd1;
          if (count == 8'd255) state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // Samples here are dropped; the swap only happens off-screen.
        if (wave_display_idle) begin
          read_index_n = ~read_index;
          state_n      = S_ARMED;
`ifdef TRIGGER_TIMEOUT_EN
          tcount_n     = '0;
`endif
        end
      end
      default: state_n = S_ARMED;
    endcase
  end

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = '0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int passed = 0;
  int total  = 0;

  wave_capture dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the next negedge with the registered
  // write outputs for this sample visible. Back-to-back calls give strobes
  // on consecutive cycles.
  task automatic send(input logic [15:0] s);
    new_sample_ready = 1'b1;
    new_sample_in    = s;
    @(negedge clk);
    new_sample_ready = 1'b0;
  endtask

  task automatic do_reset();
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (write_enable !== 1'b0) $display("FAIL reset_we got %b want 0", write_enable); else passed++;
    total++;
    if (write_address !== 9'h000) $display("FAIL reset_addr got %h want 000", write_address); else passed++;
    total++;
    if (write_sample !== 8'd0) $display("FAIL reset_data got %0d want 0", write_sample); else passed++;
    total++;
    if (read_index !== 1'b0) $display("FAIL reset_ri got %b want 0", read_index); else passed++;
  endtask

  task automatic test_capture();
    logic [8:0] ea;
    send(16'hFB00);
    total++;
    if (write_enable !== 1'b0) $display("FAIL cap_pre_we got %b want 0", write_enable); else passed++;
    send(16'h0300);
    total++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'd124)
      $display("FAIL cap_first got we=%b a=%h d=%0d want we=1 a=100 d=124",
               write_enable, write_address, write_sample);
    else passed++;
    for (int i = 1; i < 256; i++) begin
      send(16'h0100);
      ea = 9'h100 + 9'(i);
      total++;
      if (write_enable !== 1'b1 || write_address !== ea || write_sample !== 8'd126)
        $display("FAIL cap_write got we=%b a=%h d=%0d want we=1 a=%h d=126",
                 write_enable, write_address, write_sample, ea);
      else passed++;
    end
  endtask

  task automatic test_wait_swap();
    logic [8:0] ea;
    int bad;
    bad = 0;
    // Crossings offered here must be ignored while the display is busy.
    for (int i = 0; i < 50; i++) begin
      send((i % 2 == 0) ? 16'h8000 : 16'h0100);
      if (write_enable !== 1'b0 || read_index !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL wait_hold got %0d bad cycles want 0", bad); else passed++;
    wave_display_idle = 1'b1;
    @(negedge clk);
    wave_display_idle = 1'b0;
    total++;
    if (read_index !== 1'b1) $display("FAIL swap_ri got %b want 1", read_index); else passed++;
    send(16'hFF00);
    total++;
    if (write_enable !== 1'b0) $display("FAIL cap2_pre_we got %b want 0", write_enable); else passed++;
    send(16'h0000);
    total++;
    if (write_enable !== 1'b1 || write_address !== 9'h000 || write_sample !== 8'd127)
      $display("FAIL cap2_first got we=%b a=%h d=%0d want we=1 a=000 d=127",
               write_enable, write_address, write_sample);
    else passed++;
    for (int i = 1; i < 256; i++) begin
      send(16'h7F00);
      ea = 9'(i);
      total++;
      if (write_enable !== 1'b1 || write_address !== ea || write_sample !== 8'd0)
        $display("FAIL cap2_write got we=%b a=%h d=%0d want we=1 a=%h d=0",
                 write_enable, write_address, write_sample, ea);
      else passed++;
    end
    // Idle and a sample together in WAIT: swap only, nothing written.
    wave_display_idle = 1'b1;
    send(16'h0100);
    wave_display_idle = 1'b0;
    total++;
    if (write_enable !== 1'b0 || read_index !== 1'b0)
      $display("FAIL swap_vs_sample got we=%b ri=%b want we=0 ri=0", write_enable, read_index);
    else passed++;
  endtask

  task automatic test_dc();
    int bad;
    bad = 0;
    do_reset();
`ifdef TRIGGER_TIMEOUT_EN
    for (int i = 1; i < 1024; i++) begin
      send(16'h1000);
      if (write_enable !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL dc_early got %0d writes want 0", bad); else passed++;
    send(16'h1000);
    total++;
    if (write_enable !== 1'b1 || write_address !== 9'h100 || write_sample !== 8'd111)
      $display("FAIL dc_timeout got we=%b a=%h d=%0d want we=1 a=100 d=111",
               write_enable, write_address, write_sample);
    else passed++;
`else
    for (int i = 0; i < 1100; i++) begin
      send(16'h1000);
      if (write_enable !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL dc_nowrite got %0d writes want 0", bad); else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(16'hFF00);
    send(16'h0000);
    for (int i = 1; i < 100; i++) send(16'h2000);
    total++;
    if (write_enable !== 1'b1 || write_address !== 9'h163)
      $display("FAIL mid_100th got we=%b a=%h want we=1 a=163", write_enable, write_address);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (write_enable !== 1'b0 || read_index !== 1'b0)
      $display("FAIL mid_reset got we=%b ri=%b want we=0 ri=0", write_enable, read_index);
    else passed++;
    // Partial buffer is discarded: a plain sample must not resume the capture.
    send(16'h2000);
    total++;
    if (write_enable !== 1'b0) $display("FAIL mid_noresume got %b want 0", write_enable); else passed++;
    send(16'hFF00);
    send(16'h0000);
    total++;
    if (write_enable !== 1'b1 || write_address !== 9'h100)
      $display("FAIL mid_restart got we=%b a=%h want we=1 a=100", write_enable, write_address);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] ea;
    logic [7:0] ed;
    int bad;
    bad = 0;
    do_reset();
    send(16'hFF00);
    send(16'h0000);
    total++;
    if (write_enable !== 1'b1 || write_address !== 9'h100)
      $display("FAIL b2b_first got we=%b a=%h want we=1 a=100", write_enable, write_address);
    else passed++;
    for (int i = 1; i < 256; i++) begin
      send((i % 2 == 1) ? 16'h8000 : 16'h7F00);
      ea = 9'h100 + 9'(i);
      ed = (i % 2 == 1) ? 8'd255 : 8'd0;
      if (write_enable !== 1'b1 || write_address !== ea || write_sample !== ed) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL b2b_stream got %0d bad writes want 0", bad); else passed++;
    total++;
    if (write_sample !== 8'd255) $display("FAIL b2b_neg_scale got %0d want 255", write_sample); else passed++;
    send(16'h0100);
    total++;
    if (write_enable !== 1'b0) $display("FAIL b2b_257th got %b want 0", write_enable); else passed++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_wait_swap();
    test_dc();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
